// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: lane steering, req/ack FSM, fault capture.
// Optional bus timeout is compiled in with `define MEM_TIMEOUT_EN.
module mem_wb_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [63:0] ALUresult,
   input  logic [63:0] WriteData,
   input  logic [4:0]  Rd,
   input  logic        WB,
   input  logic [4:0]  M,
   input  logic        dmem_ack,
   input  logic [63:0] dmem_rdata,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [7:0]  dmem_be,
   output logic [63:0] dmem_wdata,
   output logic [63:0] wb_data_out,
   output logic [4:0]  Rd_out,
   output logic        WB_out,
   output logic [1:0]  fault_out,
   output logic        fsm_state
);

   // Handshake: dmem_req stays high until the cycle dmem_ack is seen; ack without req is ignored.
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ALIGN   = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   state_t      state;
   state_t      state_next;

   logic [1:0]  size;
   logic [2:0]  off;
   logic [5:0]  shift_amt;
   logic        mem_op;
   logic        is_store;
   logic [2:0]  align_mask;
   logic [7:0]  lane_mask;
   logic        misaligned;
   logic        access;
   logic        timeout_hit;
   logic        ack_seen;
   logic [63:0] rdata_shifted;
   logic [63:0] load_val;
   logic [7:0]  be_raw;
   logic [63:0] wdata_raw;

   assign size      = M[3:2];
   assign off       = ALUresult[2:0];
   assign shift_amt = {off, 3'b000};
   assign mem_op    = in_valid & (M[0] | M[1]);
   assign is_store  = M[1];

   always_comb begin
      align_mask = 3'b000;
      lane_mask  = 8'h01;
      case (size)
         2'b00: begin align_mask = 3'b000; lane_mask = 8'h01; end
         2'b01: begin align_mask = 3'b001; lane_mask = 8'h03; end
         2'b10: begin align_mask = 3'b011; lane_mask = 8'h0F; end
         default: begin align_mask = 3'b111; lane_mask = 8'hFF; end
      endcase
   end

   assign misaligned = mem_op & ((off & align_mask) != 3'b000);
   assign access     = mem_op & ~misaligned;

   assign be_raw        = lane_mask << off;
   assign wdata_raw     = WriteData << shift_amt;
   assign rdata_shifted = dmem_rdata >> shift_amt;

   always_comb begin
      load_val = 64'd0;
      case (size)
         2'b00:   load_val = {56'd0, rdata_shifted[7:0]};
         2'b01:   load_val = {48'd0, rdata_shifted[15:0]};
         2'b10:   load_val = {32'd0, rdata_shifted[31:0]};
         default: load_val = rdata_shifted;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] timeout_cnt;

   // The counter holds the number of ack-less BUSY cycles already completed.
   assign timeout_hit = (state == BUSY) && (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timeout_cnt <= '0;
      end else if ((state == BUSY) && !ack_seen && !timeout_hit) begin
         timeout_cnt <= timeout_cnt + 1'b1;
      end else begin
         timeout_cnt <= '0;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
`endif

   // Gating with rst drops the request the moment reset asserts, even mid-access.
   assign dmem_req   = rst & access & ~timeout_hit;
   assign ack_seen   = dmem_req & dmem_ack;
   assign stall      = dmem_req & ~dmem_ack;
   assign dmem_we    = dmem_req & is_store;
   assign dmem_addr  = dmem_req ? {ALUresult[63:3], 3'b000} : 64'd0;
   assign dmem_be    = dmem_req ? be_raw : 8'h00;
   assign dmem_wdata = (dmem_req & is_store) ? wdata_raw : 64'd0;
   assign fsm_state  = (state == BUSY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (stall) state_next = BUSY;
         end
         BUSY: begin
            if (!stall) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_data_out <= 64'd0;
         Rd_out      <= 5'd0;
         WB_out      <= 1'b0;
         fault_out   <= FAULT_NONE;
      end else if (!stall) begin
         wb_data_out <= M[4] ? load_val : ALUresult;
         Rd_out      <= Rd;
         if (!in_valid) begin
            WB_out    <= 1'b0;
            fault_out <= FAULT_NONE;
         end else if (misaligned) begin
            WB_out    <= 1'b0;
            fault_out <= FAULT_ALIGN;
         end else if (timeout_hit) begin
            WB_out    <= 1'b0;
            fault_out <= FAULT_TIMEOUT;
         end else begin
            WB_out    <= WB;
            fault_out <= FAULT_NONE;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; covers the timeout path when MEM_TIMEOUT_EN is defined.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [63:0] ALUresult;
   logic [63:0] WriteData;
   logic [4:0]  Rd;
   logic        WB;
   logic [4:0]  M;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [7:0]  dmem_be;
   logic [63:0] dmem_wdata;
   logic [63:0] wb_data_out;
   logic [4:0]  Rd_out;
   logic        WB_out;
   logic [1:0]  fault_out;
   logic        fsm_state;

   int n_vec = 0;
   int n_err = 0;

   mem_wb_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .ALUresult(ALUresult),
      .WriteData(WriteData), .Rd(Rd), .WB(WB), .M(M), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .wb_data_out(wb_data_out), .Rd_out(Rd_out), .WB_out(WB_out),
      .fault_out(fault_out), .fsm_state(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] wd,
                        input logic [4:0] rd, input logic wb, input logic [4:0] m,
                        input logic ack, input logic [63:0] rdata);
      in_valid   = v;
      ALUresult  = alu;
      WriteData  = wd;
      Rd         = rd;
      WB         = wb;
      M          = m;
      dmem_ack   = ack;
      dmem_rdata = rdata;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      drive(1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0);
      #12;
      n_vec++;
      if ({wb_data_out, Rd_out, WB_out, fault_out} !== 72'd0) begin
         n_err++;
         $display("FAIL reset_regs: got wb=%h rd=%0d we=%b f=%b want all 0", wb_data_out, Rd_out, WB_out, fault_out);
      end
      n_vec++;
      if ({fsm_state, dmem_req, stall} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_fsm: got st=%b req=%b stall=%b want 000", fsm_state, dmem_req, stall);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_alu;
      @(negedge clk);
      drive(1'b1, 64'h1234, 64'd0, 5'd5, 1'b1, 5'b00000, 1'b0, 64'd0);
      #1;
      n_vec++;
      if ({stall, dmem_req} !== 2'b00) begin
         n_err++;
         $display("FAIL alu_nostall: got stall=%b req=%b want 00", stall, dmem_req);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({wb_data_out, Rd_out, WB_out, fault_out} !== {64'h1234, 5'd5, 1'b1, 2'b00}) begin
         n_err++;
         $display("FAIL alu_wb: got wb=%h rd=%0d we=%b f=%b want 1234/5/1/00", wb_data_out, Rd_out, WB_out, fault_out);
      end
   endtask

   task automatic test_byte_load;
      int high_cnt;
      high_cnt = 0;
      @(negedge clk);
      drive(1'b1, 64'h1003, 64'd0, 5'd7, 1'b1, 5'b10001, 1'b0, 64'h8877665544332211);
      #1;
      n_vec++;
      if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 64'h1000}) begin
         n_err++;
         $display("FAIL bload_req: got req=%b we=%b addr=%h want 1/0/1000", dmem_req, dmem_we, dmem_addr);
      end
      if (stall === 1'b1) high_cnt++;
      @(posedge clk); #1;
      n_vec++;
      if ({fsm_state, wb_data_out} !== {1'b1, 64'h1234}) begin
         n_err++;
         $display("FAIL bload_hold: got st=%b wb=%h want 1/1234", fsm_state, wb_data_out);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         if (stall === 1'b1) high_cnt++;
      end
      @(negedge clk);
      dmem_ack = 1'b1;
      #1;
      if (stall === 1'b1) high_cnt++;
      n_vec++;
      if (high_cnt !== 3) begin
         n_err++;
         $display("FAIL bload_stall_cycles: got %0d want 3", high_cnt);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({wb_data_out, Rd_out, WB_out, fault_out, fsm_state} !== {64'h44, 5'd7, 1'b1, 2'b00, 1'b0}) begin
         n_err++;
         $display("FAIL bload_wb: got wb=%h rd=%0d we=%b f=%b st=%b want 44/7/1/00/0",
                  wb_data_out, Rd_out, WB_out, fault_out, fsm_state);
      end
   endtask

   task automatic test_word_store;
      @(negedge clk);
      drive(1'b1, 64'h2004, 64'hDEADBEEF, 5'd2, 1'b0, 5'b01010, 1'b1, 64'd0);
      #1;
      n_vec++;
      if ({dmem_req, dmem_we, dmem_be, stall} !== {1'b1, 1'b1, 8'hF0, 1'b0}) begin
         n_err++;
         $display("FAIL wstore_ctl: got req=%b we=%b be=%h stall=%b want 1/1/f0/0", dmem_req, dmem_we, dmem_be, stall);
      end
      n_vec++;
      if (dmem_wdata !== 64'hDEADBEEF00000000) begin
         n_err++;
         $display("FAIL wstore_wdata: got %h want deadbeef00000000", dmem_wdata);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({wb_data_out, WB_out, fault_out, fsm_state} !== {64'h2004, 1'b0, 2'b00, 1'b0}) begin
         n_err++;
         $display("FAIL wstore_wb: got wb=%h we=%b f=%b st=%b want 2004/0/00/0", wb_data_out, WB_out, fault_out, fsm_state);
      end
   endtask

   task automatic test_rw_as_store;
      @(negedge clk);
      drive(1'b1, 64'h5005, 64'hAB, 5'd1, 1'b0, 5'b00011, 1'b1, 64'd0);
      #1;
      n_vec++;
      if ({dmem_we, dmem_be, dmem_wdata} !== {1'b1, 8'h20, 64'h0000AB0000000000}) begin
         n_err++;
         $display("FAIL rw_store: got we=%b be=%h wd=%h want 1/20/0000ab0000000000", dmem_we, dmem_be, dmem_wdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_misaligned;
      @(negedge clk);
      drive(1'b1, 64'h3001, 64'd0, 5'd9, 1'b1, 5'b10101, 1'b1, 64'd0);
      #1;
      n_vec++;
      if ({dmem_req, stall} !== 2'b00) begin
         n_err++;
         $display("FAIL misalign_req: got req=%b stall=%b want 00", dmem_req, stall);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({Rd_out, WB_out, fault_out} !== {5'd9, 1'b0, 2'b01}) begin
         n_err++;
         $display("FAIL misalign_wb: got rd=%0d we=%b f=%b want 9/0/01", Rd_out, WB_out, fault_out);
      end
      @(negedge clk);
      drive(1'b1, 64'h77, 64'd0, 5'd10, 1'b1, 5'b00000, 1'b0, 64'd0);
      @(posedge clk); #1;
      n_vec++;
      if ({wb_data_out, WB_out, fault_out} !== {64'h77, 1'b1, 2'b00}) begin
         n_err++;
         $display("FAIL misalign_oneslot: got wb=%h we=%b f=%b want 77/1/00", wb_data_out, WB_out, fault_out);
      end
   endtask

   task automatic test_wide_loads;
      @(negedge clk);
      drive(1'b1, 64'h4000, 64'd0, 5'd11, 1'b1, 5'b11101, 1'b1, 64'h0123456789ABCDEF);
      #1;
      n_vec++;
      if ({dmem_be, stall} !== {8'hFF, 1'b0}) begin
         n_err++;
         $display("FAIL dload_be: got be=%h stall=%b want ff/0", dmem_be, stall);
      end
      @(posedge clk); #1;
      n_vec++;
      if (wb_data_out !== 64'h0123456789ABCDEF) begin
         n_err++;
         $display("FAIL dload_wb: got %h want 0123456789abcdef", wb_data_out);
      end
      @(negedge clk);
      drive(1'b1, 64'h4006, 64'd0, 5'd12, 1'b1, 5'b10101, 1'b1, 64'h0123456789ABCDEF);
      #1;
      n_vec++;
      if (dmem_be !== 8'hC0) begin
         n_err++;
         $display("FAIL hload_be: got %h want c0", dmem_be);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({wb_data_out, fault_out} !== {64'h0123, 2'b00}) begin
         n_err++;
         $display("FAIL hload_wb: got wb=%h f=%b want 0123/00", wb_data_out, fault_out);
      end
   endtask

   task automatic test_bubble_and_stray_ack;
      @(negedge clk);
      drive(1'b0, 64'h10, 64'd0, 5'd3, 1'b1, 5'b00001, 1'b1, 64'd0);
      #1;
      n_vec++;
      if ({dmem_req, stall} !== 2'b00) begin
         n_err++;
         $display("FAIL bubble_req: got req=%b stall=%b want 00", dmem_req, stall);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({wb_data_out, Rd_out, WB_out, fault_out, fsm_state} !== {64'h10, 5'd3, 1'b0, 2'b00, 1'b0}) begin
         n_err++;
         $display("FAIL bubble_wb: got wb=%h rd=%0d we=%b f=%b st=%b want 10/3/0/00/0",
                  wb_data_out, Rd_out, WB_out, fault_out, fsm_state);
      end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout;
      int high_cnt;
      high_cnt = 0;
      @(negedge clk);
      drive(1'b1, 64'h6000, 64'd0, 5'd4, 1'b1, 5'b10001, 1'b0, 64'h55AA);
      for (int i = 0; i < 16; i++) begin
         #1;
         if (stall === 1'b1) high_cnt++;
         @(negedge clk);
      end
      #1;
      n_vec++;
      if (high_cnt !== 16) begin
         n_err++;
         $display("FAIL tmo_stall_cycles: got %0d want 16", high_cnt);
      end
      n_vec++;
      if ({stall, dmem_req, fsm_state} !== 3'b001) begin
         n_err++;
         $display("FAIL tmo_drop: got stall=%b req=%b st=%b want 0/0/1", stall, dmem_req, fsm_state);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({WB_out, fault_out, fsm_state} !== {1'b0, 2'b10, 1'b0}) begin
         n_err++;
         $display("FAIL tmo_fault: got we=%b f=%b st=%b want 0/10/0", WB_out, fault_out, fsm_state);
      end
      @(negedge clk);
      drive(1'b1, 64'h99, 64'd0, 5'd6, 1'b1, 5'b00000, 1'b0, 64'd0);
      @(posedge clk); #1;
      n_vec++;
      if ({wb_data_out, Rd_out, WB_out, fault_out} !== {64'h99, 5'd6, 1'b1, 2'b00}) begin
         n_err++;
         $display("FAIL tmo_after_alu: got wb=%h rd=%0d we=%b f=%b want 99/6/1/00", wb_data_out, Rd_out, WB_out, fault_out);
      end
   endtask
`else
   task automatic test_timeout;
      int low_cnt;
      int f10_cnt;
      low_cnt = 0;
      f10_cnt = 0;
      @(negedge clk);
      drive(1'b1, 64'h6000, 64'd0, 5'd4, 1'b1, 5'b10001, 1'b0, 64'h55AA);
      for (int i = 0; i < 40; i++) begin
         #1;
         if (stall !== 1'b1) low_cnt++;
         if (fault_out === 2'b10) f10_cnt++;
         @(negedge clk);
      end
      n_vec++;
      if ({low_cnt, f10_cnt} !== {32'd0, 32'd0}) begin
         n_err++;
         $display("FAIL busy_forever: got stall_low=%0d fault10=%0d want 0/0", low_cnt, f10_cnt);
      end
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({wb_data_out, WB_out, fault_out, fsm_state} !== {64'hAA, 1'b1, 2'b00, 1'b0}) begin
         n_err++;
         $display("FAIL busy_ack: got wb=%h we=%b f=%b st=%b want aa/1/00/0", wb_data_out, WB_out, fault_out, fsm_state);
      end
   endtask
`endif

   task automatic test_reset_mid_busy;
      @(negedge clk);
      drive(1'b1, 64'h7000, 64'd0, 5'd8, 1'b1, 5'b10001, 1'b0, 64'd0);
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if ({fsm_state, dmem_req} !== 2'b11) begin
         n_err++;
         $display("FAIL rstbusy_pre: got st=%b req=%b want 11", fsm_state, dmem_req);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if ({dmem_req, stall, fsm_state, wb_data_out, Rd_out, WB_out, fault_out} !== 75'd0) begin
         n_err++;
         $display("FAIL rstbusy_now: got req=%b stall=%b st=%b wb=%h rd=%0d we=%b f=%b want all 0",
                  dmem_req, stall, fsm_state, wb_data_out, Rd_out, WB_out, fault_out);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({fsm_state, dmem_req} !== 2'b00) begin
         n_err++;
         $display("FAIL rstbusy_post: got st=%b req=%b want 00", fsm_state, dmem_req);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_byte_load();
      test_word_store();
      test_rw_as_store();
      test_misaligned();
      test_wide_loads();
      test_bubble_and_stray_ack();
      test_timeout();
      test_reset_mid_busy();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
